// File: rtl/branch_gshare_pht_if.sv
// Prediction and resolution port bundle for the gshare predictor.
// The fetch/commit side drives through master; the predictor sits on slave.
interface branch_gshare_pht_if #(
  parameter int GHR_W = 8
);
  logic [31:0]      pc;
  logic             branch_en;
  logic             taken_en;
  logic [GHR_W-1:0] ghr_snap;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_taken;
  logic             upd_mispredict;
  logic [15:0]      mispred_cnt;

  modport master (
    output pc, branch_en, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    input  taken_en, ghr_snap, mispred_cnt
  );
  modport slave (
    input  pc, branch_en, upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    output taken_en, ghr_snap, mispred_cnt
  );
endinterface

// File: rtl/branch_gshare_pht.sv
// gshare direction predictor: speculative GHR XOR PC indexes a flop-based
// table of 2-bit saturating counters; trained and GHR-recovered from commit.
module branch_gshare_pht #(
  parameter int GHR_W   = 8,
  parameter int PHT_IDX = 8
) (
  input logic                 clk,
  input logic                 resetn,
  branch_gshare_pht_if.slave  bp
);
  localparam int PHT_N = 1 << PHT_IDX;

  logic [PHT_N-1:0][1:0] pht;
  logic [GHR_W-1:0]      ghr;
  logic [15:0]           cnt;
  logic [PHT_IDX-1:0]    idx, uidx;
  logic [1:0]            uctr, unext;
  logic                  recover;

  assign idx  = bp.pc[PHT_IDX+1:2]     ^ PHT_IDX'(ghr);
  assign uidx = bp.upd_pc[PHT_IDX+1:2] ^ PHT_IDX'(bp.upd_ghr);

  // Read is purely combinational off current state: no write-to-read bypass.
  assign bp.taken_en    = pht[idx][1];
  assign bp.ghr_snap    = ghr;
  assign bp.mispred_cnt = cnt;

  assign recover = bp.upd_valid & bp.upd_mispredict;

  always_comb begin
    uctr  = pht[uidx];
    unext = uctr;
    if (bp.upd_taken) begin
      if (uctr != 2'b11) unext = uctr + 2'b01;
    end else begin
      if (uctr != 2'b00) unext = uctr - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pht <= {PHT_N{2'b01}};
    end else if (bp.upd_valid) begin
      pht[uidx] <= unext;
    end
  end

  // Recovery from the committed snapshot wins over the speculative shift.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ghr <= '0;
    end else if (recover) begin
      ghr <= {bp.upd_ghr[GHR_W-2:0], bp.upd_taken};
    end else if (bp.branch_en) begin
      ghr <= {ghr[GHR_W-2:0], bp.taken_en};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (recover && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_gshare_pht.sv
// Directed bench for branch_gshare_pht with hand-computed expectations.
module tb_branch_gshare_pht;
  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  branch_gshare_pht_if #(.GHR_W(8)) bp ();

  branch_gshare_pht #(.GHR_W(8), .PHT_IDX(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bp     (bp.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic v, input logic [7:0] g, input logic t, input logic m);
    bp.upd_valid      = v;
    bp.upd_pc         = 32'h0000_1000;
    bp.upd_ghr        = g;
    bp.upd_taken      = t;
    bp.upd_mispredict = m;
  endtask

  initial begin
    resetn       = 1'b0;
    bp.pc        = 32'h0000_1000;
    bp.branch_en = 1'b0;
    upd(1'b0, 8'h00, 1'b0, 1'b0);
    #12;
    chk("rst_taken_during", 32'(bp.taken_en), 32'd0);
    chk("rst_ghr_during",   32'(bp.ghr_snap), 32'd0);
    resetn = 1'b1;
    tick();
    chk("rst_taken", 32'(bp.taken_en),    32'd0);
    chk("rst_ghr",   32'(bp.ghr_snap),    32'd0);
    chk("rst_cnt",   32'(bp.mispred_cnt), 32'd0);

    // Entry 0x00: 01 -> 10 -> 11 -> 11 -> 11, then 10 -> 01
    upd(1'b1, 8'h00, 1'b1, 1'b0);
    #1;
    chk("nobypass_same_cycle", 32'(bp.taken_en), 32'd0);
    tick();
    chk("train_t1", 32'(bp.taken_en), 32'd1);
    tick();
    chk("train_t2", 32'(bp.taken_en), 32'd1);
    tick();
    chk("train_t3", 32'(bp.taken_en), 32'd1);
    tick();
    chk("train_t4", 32'(bp.taken_en), 32'd1);
    upd(1'b1, 8'h00, 1'b0, 1'b0);
    tick();
    chk("train_nt1", 32'(bp.taken_en), 32'd1);
    tick();
    chk("train_nt2", 32'(bp.taken_en), 32'd0);

    // Train entries 0x00, 0x01, 0x03 to strongly taken
    upd(1'b1, 8'h00, 1'b1, 1'b0); tick(); tick();
    upd(1'b1, 8'h01, 1'b1, 1'b0); tick(); tick();
    upd(1'b1, 8'h03, 1'b1, 1'b0); tick(); tick();
    upd(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ghr_not_moved_by_training", 32'(bp.ghr_snap), 32'd0);

    bp.branch_en = 1'b1;
    #1;
    chk("shift_snap0",  32'(bp.ghr_snap), 32'h00);
    chk("shift_taken0", 32'(bp.taken_en), 32'd1);
    tick();
    chk("shift_snap1",  32'(bp.ghr_snap), 32'h01);
    chk("shift_taken1", 32'(bp.taken_en), 32'd1);
    tick();
    chk("shift_snap2",  32'(bp.ghr_snap), 32'h03);
    chk("shift_taken2", 32'(bp.taken_en), 32'd1);
    tick();
    bp.branch_en = 1'b0;
    #1;
    chk("shift_final", 32'(bp.ghr_snap), 32'h07);
    tick();
    chk("ghr_hold", 32'(bp.ghr_snap), 32'h07);

    // Recovery beats a same-cycle speculative shift
    bp.branch_en = 1'b1;
    upd(1'b1, 8'h05, 1'b0, 1'b1);
    tick();
    bp.branch_en = 1'b0;
    upd(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("recover_ghr", 32'(bp.ghr_snap),    32'h0A);
    chk("recover_cnt", 32'(bp.mispred_cnt), 32'd1);
    chk("recover_taken_idx0a", 32'(bp.taken_en), 32'd0);

    // Mispredict flag without upd_valid is ignored
    upd(1'b0, 8'h33, 1'b1, 1'b1);
    tick();
    chk("unqual_mispred_cnt", 32'(bp.mispred_cnt), 32'd1);
    chk("unqual_mispred_ghr", 32'(bp.ghr_snap),    32'h0A);

    // Build ghr = 0x5A via recovery: {0x2D[6:0], 0}
    upd(1'b1, 8'h2D, 1'b0, 1'b1);
    tick();
    chk("ghr_5a",     32'(bp.ghr_snap),    32'h5A);
    chk("cnt_2",      32'(bp.mispred_cnt), 32'd2);

    // Async reset mid-cycle with a pending update that must be lost
    upd(1'b1, 8'h00, 1'b1, 1'b1);
    bp.branch_en = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_ghr", 32'(bp.ghr_snap),    32'd0);
    chk("async_rst_cnt", 32'(bp.mispred_cnt), 32'd0);
    tick();
    upd(1'b0, 8'h00, 1'b0, 1'b0);
    bp.branch_en = 1'b0;
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bp.pc = 32'h0000_1000 | (32'(i) << 2);
      #1;
      chk($sformatf("post_rst_taken_idx%0d", i), 32'(bp.taken_en), 32'd0);
    end
    chk("post_rst_ghr", 32'(bp.ghr_snap),    32'd0);
    chk("post_rst_cnt", 32'(bp.mispred_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_gshare_pht.md
# branch_gshare_pht

Global-history (gshare) direction predictor that supplies the global-predictor result to the tournament chooser in the fetch stage. It holds a speculative global history register (GHR) and a pattern history table (PHT) of 2-bit saturating counters. Each fetch it produces a taken/not-taken prediction plus the GHR snapshot that produced it. It is trained from the commit/branch-resolution port and restores the GHR on a misprediction.

## Interface
- GHR_W, 8, global history length in bits; legal range 2..PHT_IDX.
- PHT_IDX, 8, PHT index width; the PHT has 2^PHT_IDX entries.
- clk  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pc  in  32  fetch PC to predict.
- branch_en  in  1  fetch slot holds a conditional branch; enables the speculative GHR shift.
- taken_en  out  1  predicted direction (1 = taken); combinational.
- ghr_snap  out  GHR_W  GHR value used to form this cycle's index; carried down the pipe for update.
- upd_valid  in  1  resolved branch update this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_ghr  in  GHR_W  ghr_snap captured when that branch was predicted.
- upd_taken  in  1  actual direction.
- upd_mispredict  in  1  the prediction was wrong; qualified by upd_valid.
- mispred_cnt  out  16  count of mispredicts, saturating.

## Operation
- Prediction index: idx = pc[PHT_IDX+1:2] XOR {zeros, ghr}; the GHR is zero-extended to PHT_IDX bits.
- Prediction output:
  - taken_en = PHT[idx][1].
  - ghr_snap = ghr.
  - Both outputs are valid regardless of branch_en.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Training: when upd_valid = 1, compute uidx = upd_pc[PHT_IDX+1:2] XOR {zeros, upd_ghr}.
  - If upd_taken = 1, PHT[uidx] increments, saturating at 11.
  - If upd_taken = 0, PHT[uidx] decrements, saturating at 00.
  - Exactly one entry is written per cycle.
- GHR next-state, in priority order:
  1. upd_valid & upd_mispredict: ghr <= {upd_ghr[GHR_W-2:0], upd_taken}. This is recovery; any same-cycle speculative shift is discarded.
  2. Else if branch_en: ghr <= {ghr[GHR_W-2:0], taken_en}. This is the speculative shift.
  3. Else ghr holds.
- mispred_cnt: increments on each upd_valid & upd_mispredict and holds at 0xFFFF.
- Reset (resetn = 0, asynchronous):
  - Every PHT entry is set to 01.
  - ghr is set to 0 and mispred_cnt to 0.
  - As a result, taken_en = 0 and ghr_snap = 0 throughout reset and immediately after it.
- Reset asserted mid-operation: all state clears immediately. An update presented in the same cycle is lost.
- The PHT is a flop array, because the reset requirement rules out SRAM.

## Timing
- taken_en and ghr_snap are combinational from pc and the current ghr/PHT state. Zero-cycle latency; no registers on the output path.
- Training writes at the edge where upd_valid is sampled. The new counter value is visible to predictions from the next cycle.
- Same-cycle read and write of the same entry: there is no bypass, so the prediction uses the old value.
- GHR changes (shift or recovery) take effect at the edge where they are sampled, so the next cycle's idx uses the new ghr.
- Training and the speculative shift are independent of each other. Only recovery overrides the shift.
- No handshake and no stall: the block accepts one prediction and one update every cycle.

## Test plan
Defaults for all scenarios: GHR_W = 8, PHT_IDX = 8.
- Reset: release resetn, pc = 0x0000_1000, branch_en = 0 -> taken_en = 0, ghr_snap = 0x00, mispred_cnt = 0.
- Training and saturation, all with upd_pc = 0x0000_1000, upd_ghr = 0x00 (so uidx = 0x00), and pc = 0x0000_1000 read back:
  - Two taken updates -> counter 01→10→11, taken_en = 1.
  - Two further taken updates -> counter stays at 11.
  - Two not-taken updates -> counter 11→10→01; taken_en = 1 after the first and 0 after the second.
- Speculative shift: with entries trained taken, branch_en = 1 for 3 cycles with taken_en = 1 -> ghr_snap reads 0x00, 0x01, 0x03, then ghr = 0x07.
- Recovery priority: ghr = 0x07; in the same cycle drive branch_en = 1, upd_valid = 1, upd_mispredict = 1, upd_ghr = 0x05, upd_taken = 0 -> ghr = 0x0A next cycle and mispred_cnt increments by 1.
- No bypass: in the same cycle, update entry 0x00 from 01 (taken) while predicting pc = 0x0000_1000 with ghr = 0 -> taken_en = 0 in that cycle and 1 in the next.
- Reset mid-operation: with ghr = 0x5A and several entries trained, assert resetn = 0 asynchronously -> ghr = 0 immediately and all entries predict not-taken after release.
